// File: rtl/scan_reg_bridge.sv
// Serial scan-port to register-block command bridge: 32-bit frames become writes or reads.
// Optional odd-parity frame checking is enabled by defining SCAN_PARITY_EN.
module scan_reg_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        scan_in,
  input  logic        scan_upd,
  output logic        scan_out,
  output logic        reg_wen,
  output logic        reg_ren,
  output logic [16:0] reg_cr_wdata,
  input  logic [16:0] reg_cr_rdata,
  input  logic [14:0] reg_sr_rdata,
  input  logic        reg_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  // The count starts at 0 on entry, so READ lasts exactly TIMEOUT cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_r;
  state_t      state_s;
  logic [31:0] sh_r;
  logic [31:0] sh_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_s;
  logic [16:0] wdata_r;
  logic [16:0] wdata_s;
  logic        err_r;
  logic        err_s;
  logic        wen_r;
  logic        wen_s;
  logic        ren_r;
  logic        ren_s;
  logic        busy_r;
  logic        busy_s;
  logic [1:0]  op_s;
  logic        frame_ok_s;
  logic        upd_go_s;
  logic        timeout_s;
  logic        conflict_s;
  logic        err_set_s;
  logic        err_clr_s;

`ifdef SCAN_PARITY_EN
  function automatic logic frame_parity_ok(input logic [31:0] frame);
    return ^{frame[31:29], frame[16:0]};
  endfunction

  assign frame_ok_s = frame_parity_ok(sh_r);
`else
  assign frame_ok_s = 1'b1;
`endif

  assign op_s       = sh_r[31:30];
  assign upd_go_s   = (state_r == ST_IDLE) && scan_upd && !scan_en;
  assign timeout_s  = (cnt_r == TIMEOUT_LAST);
  assign conflict_s = (state_r != ST_IDLE) && (scan_en || scan_upd);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (upd_go_s && frame_ok_s && (op_s == OP_WRITE)) begin
          state_s = ST_WRITE;
        end else if (upd_go_s && frame_ok_s && (op_s == OP_READ)) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: state_s = ST_IDLE;
      ST_READ: begin
        if (reg_ready || timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_READ;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Shift register, timeout counter, write data and error flag next values
  always_comb begin
    sh_s      = sh_r;
    cnt_s     = cnt_r;
    wdata_s   = wdata_r;
    err_set_s = conflict_s;
    err_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = 8'd0;
        if (scan_en) begin
          sh_s = {scan_in, sh_r[31:1]};
          if (scan_upd) begin
            err_set_s = 1'b1;
          end else begin
            err_set_s = 1'b0;
          end
        end else if (scan_upd) begin
          if (!frame_ok_s) begin
            // A corrupted NOP neither sets nor clears the flag.
            err_set_s = (op_s != OP_NOP);
          end else begin
            case (op_s)
              OP_NOP:   err_clr_s = 1'b1;
              OP_WRITE: wdata_s   = sh_r[16:0];
              OP_READ:  cnt_s     = 8'd0;
              default:  err_set_s = 1'b1;
            endcase
          end
        end else begin
          err_set_s = 1'b0;
        end
      end
      ST_WRITE: begin
        cnt_s = 8'd0;
      end
      ST_READ: begin
        if (reg_ready) begin
          sh_s  = {reg_sr_rdata, reg_cr_rdata};
          cnt_s = 8'd0;
        end else if (timeout_s) begin
          err_set_s = 1'b1;
          cnt_s     = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        cnt_s = 8'd0;
      end
    endcase

    if (err_set_s) begin
      err_s = 1'b1;
    end else if (err_clr_s) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // Output decode from the upcoming state so strobes are registered
  always_comb begin
    wen_s  = 1'b0;
    ren_s  = 1'b0;
    busy_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        wen_s  = 1'b0;
        ren_s  = 1'b0;
        busy_s = 1'b0;
      end
      ST_WRITE: begin
        wen_s  = 1'b1;
        busy_s = 1'b1;
      end
      ST_READ: begin
        ren_s  = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        wen_s  = 1'b0;
        ren_s  = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r    <= 32'd0;
      cnt_r   <= 8'd0;
      wdata_r <= 17'd0;
      err_r   <= 1'b0;
      wen_r   <= 1'b0;
      ren_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      sh_r    <= sh_s;
      cnt_r   <= cnt_s;
      wdata_r <= wdata_s;
      err_r   <= err_s;
      wen_r   <= wen_s;
      ren_r   <= ren_s;
      busy_r  <= busy_s;
    end
  end

  assign scan_out     = sh_r[0];
  assign reg_wen      = wen_r;
  assign reg_ren      = ren_r;
  assign reg_cr_wdata = wdata_r;
  assign busy         = busy_r;
  assign err          = err_r;

endmodule

// File: tb/tb_scan_reg_bridge.sv
// Directed bench for scan_reg_bridge: frames, read handshake, timeout, misuse and parity.
module tb_scan_reg_bridge;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic        scan_in;
  logic        scan_upd;
  logic        scan_out;
  logic        reg_wen;
  logic        reg_ren;
  logic [16:0] reg_cr_wdata;
  logic [16:0] reg_cr_rdata;
  logic [14:0] reg_sr_rdata;
  logic        reg_ready;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  int r0;
  int w0;
  logic [31:0] f;
  logic [31:0] f2;
  logic [31:0] got;

  scan_reg_bridge #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_en      (scan_en),
    .scan_in      (scan_in),
    .scan_upd     (scan_upd),
    .scan_out     (scan_out),
    .reg_wen      (reg_wen),
    .reg_ren      (reg_ren),
    .reg_cr_wdata (reg_cr_wdata),
    .reg_cr_rdata (reg_cr_rdata),
    .reg_sr_rdata (reg_sr_rdata),
    .reg_ready    (reg_ready),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe-cycle counters, sampled on the active edge
  always @(posedge clk) begin
    if (reg_ren) ren_cnt <= ren_cnt + 1;
    if (reg_wen) wen_cnt <= wen_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkframe(input logic [1:0] op, input logic [16:0] d);
    logic [31:0] fr;
    fr = {op, 1'b0, 12'h000, d};
    fr[29] = ~(^{op, d});
    return fr;
  endfunction

  task automatic shift_xfer(input logic [31:0] din, output logic [31:0] dout);
    scan_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dout[i] = scan_out;
      scan_in = din[i];
      step();
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic upd();
    scan_upd = 1'b1;
    step();
    scan_upd = 1'b0;
  endtask

  task automatic nop_clear(input string tag);
    logic [31:0] dummy;
    shift_xfer(mkframe(2'b00, 17'h00000), dummy);
    upd();
    check(tag, err, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; scan_en = 1'b0; scan_in = 1'b0; scan_upd = 1'b0;
    reg_ready = 1'b0; reg_cr_rdata = 17'h00000; reg_sr_rdata = 15'h0000;
    step(); step();
    rst_n = 1'b1;
    step();

    // Misuse during a partial frame sets err, then reset lands mid-frame
    scan_en = 1'b1; scan_in = 1'b1;
    step(); step();
    scan_upd = 1'b1;
    step();
    scan_upd = 1'b0;
    step();
    check("pre_rst_err", err, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_scan_out", scan_out, 32'd0);
    check("rst_wen", reg_wen, 32'd0);
    check("rst_ren", reg_ren, 32'd0);
    check("rst_wdata", reg_cr_wdata, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_err", err, 32'd0);
    scan_en = 1'b0; scan_in = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // WRITE
    f = mkframe(2'b01, 17'h1ABCD);
    shift_xfer(f, got);
    check("shift_lsb", scan_out, 32'd1);
    w0 = wen_cnt;
    upd();
    check("wr_wen", reg_wen, 32'd1);
    check("wr_busy", busy, 32'd1);
    check("wr_ren", reg_ren, 32'd0);
    check("wr_wdata", reg_cr_wdata, 32'h1ABCD);
    step();
    check("wr_wen_off", reg_wen, 32'd0);
    check("wr_busy_off", busy, 32'd0);
    check("wr_wdata_hold", reg_cr_wdata, 32'h1ABCD);
    check("wr_wen_cycles", wen_cnt - w0, 32'd1);

    // READ with one-cycle ready latency
    shift_xfer(mkframe(2'b10, 17'h00000), got);
    r0 = ren_cnt;
    upd();
    check("rd_ren", reg_ren, 32'd1);
    check("rd_busy", busy, 32'd1);
    check("rd_wen", reg_wen, 32'd0);
    step();
    check("rd_ren_wait", reg_ren, 32'd1);
    reg_ready = 1'b1; reg_cr_rdata = 17'h00F0F; reg_sr_rdata = 15'h5A5A;
    step();
    reg_ready = 1'b0; reg_cr_rdata = 17'h00000; reg_sr_rdata = 15'h0000;
    check("rd_ren_off", reg_ren, 32'd0);
    check("rd_busy_off", busy, 32'd0);
    check("rd_ren_cycles", ren_cnt - r0, 32'd2);
    shift_xfer(32'h0000_0000, got);
    check("rd_shift_out", got, 32'hB4B40F0F);
    check("rd_err", err, 32'd0);

    // READ timeout, then NOP clears err
    f = mkframe(2'b10, 17'h0A5A5);
    shift_xfer(f, got);
    r0 = ren_cnt;
    upd();
    for (int k = 0; k < 40 && busy; k++) step();
    check("to_done", busy, 32'd0);
    check("to_ren_cycles", ren_cnt - r0, 32'd15);
    check("to_err", err, 32'd1);
    shift_xfer(mkframe(2'b00, 17'h00000), got);
    check("to_sh_kept", got, f);
    check("to_err_held", err, 32'd1);
    upd();
    check("to_nop_clr", err, 32'd0);

    // scan_upd while busy in WRITE
    f = mkframe(2'b01, 17'h00033);
    shift_xfer(f, got);
    w0 = wen_cnt;
    upd();
    scan_upd = 1'b1;
    step();
    scan_upd = 1'b0;
    check("busy_upd_err", err, 32'd1);
    check("busy_upd_wen_cycles", wen_cnt - w0, 32'd1);
    check("busy_upd_wdata", reg_cr_wdata, 32'h00033);

    // scan_en while busy in READ: shift register must stay frozen
    nop_clear("nop_clr_a");
    shift_xfer(mkframe(2'b10, 17'h00002), got);
    r0 = ren_cnt;
    upd();
    scan_en = 1'b1; scan_in = 1'b1;
    step();
    scan_en = 1'b0; scan_in = 1'b0;
    check("busy_en_frozen", scan_out, 32'd0);
    check("busy_en_err", err, 32'd1);
    reg_ready = 1'b1; reg_cr_rdata = 17'h00001;
    step();
    reg_ready = 1'b0; reg_cr_rdata = 17'h00000;
    check("busy_en_ren_cycles", ren_cnt - r0, 32'd2);
    check("busy_en_capture", scan_out, 32'd1);

    // scan_upd together with scan_en
    nop_clear("nop_clr_b");
    f = mkframe(2'b01, 17'h00055);
    shift_xfer(f, got);
    w0 = wen_cnt;
    scan_en = 1'b1; scan_upd = 1'b1; scan_in = f[0];
    step();
    scan_en = 1'b0; scan_upd = 1'b0; scan_in = 1'b0;
    step();
    check("en_upd_err", err, 32'd1);
    check("en_upd_wen_cycles", wen_cnt - w0, 32'd0);
    check("en_upd_wdata", reg_cr_wdata, 32'h00033);

    // Reserved op
    nop_clear("nop_clr_c");
    shift_xfer(mkframe(2'b11, 17'h1FFFF), got);
    w0 = wen_cnt; r0 = ren_cnt;
    upd();
    step();
    check("rsv_err", err, 32'd1);
    check("rsv_wen_cycles", wen_cnt - w0, 32'd0);
    check("rsv_ren_cycles", ren_cnt - r0, 32'd0);
    check("rsv_busy", busy, 32'd0);

    // Parity bit: honoured only when the check is compiled in
    nop_clear("nop_clr_d");
    f = mkframe(2'b01, 17'h0F00F);
    shift_xfer(f, got);
    w0 = wen_cnt;
    upd();
    step();
    check("par_ok_wen_cycles", wen_cnt - w0, 32'd1);
    check("par_ok_wdata", reg_cr_wdata, 32'h0F00F);
    f2 = f ^ 32'h2000_0000;
    shift_xfer(f2, got);
    w0 = wen_cnt;
    upd();
    step();
`ifdef SCAN_PARITY_EN
    check("par_bad_err", err, 32'd1);
    check("par_bad_wen_cycles", wen_cnt - w0, 32'd0);
`else
    check("par_ign_err", err, 32'd0);
    check("par_ign_wen_cycles", wen_cnt - w0, 32'd1);
`endif
    check("par_wdata", reg_cr_wdata, 32'h0F00F);

    // Reset in the middle of READ
    shift_xfer(mkframe(2'b10, 17'h00001), got);
    upd();
    step();
    check("mid_rd_ren", reg_ren, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rd_rst_ren", reg_ren, 32'd0);
    check("mid_rd_rst_busy", busy, 32'd0);
    check("mid_rd_rst_err", err, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_rd_scan_out", scan_out, 32'd0);
    check("mid_rd_idle", busy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
